// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - RV32I load/store unit with internal word RAM and sticky fault capture
// Combinational loads, synchronous byte-lane stores, first-fault-wins error register.
module data_memory_lsu #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mem_Read_i,
  input  logic                  Mem_Write_i,
  input  logic [2:0]            Funct3_i,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic [DATA_WIDTH-1:0] Read_Data_o,
  output logic                  Access_Error_o,
  output logic                  Fault_Valid_o,
  output logic [1:0]            Fault_Cause_o,
  output logic [DATA_WIDTH-1:0] Fault_Addr_o,
  input  logic                  Fault_Clear_i
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [DATA_WIDTH-3:0] DEPTH_LIM = (DATA_WIDTH-2)'(MEMORY_DEPTH);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_FUNCT3   = 2'b11;

  logic [DATA_WIDTH-1:0] ram [MEMORY_DEPTH];

  logic [DATA_WIDTH-1:0] offset;
  logic [DATA_WIDTH-3:0] word_idx;
  logic [1:0]            lane;
  logic [IDX_W-1:0]      ram_idx;
  logic                  access;
  logic                  load_ok;
  logic                  store_ok;
  logic                  bad_funct3;
  logic                  misaligned;
  logic                  out_of_range;
  logic [1:0]            cause;

  assign offset   = Address_i - BASE_ADDR;
  assign word_idx = offset[DATA_WIDTH-1:2];
  assign lane     = offset[1:0];
  assign ram_idx  = word_idx[IDX_W-1:0];
  assign access   = Mem_Read_i | Mem_Write_i;

  always_comb begin
    load_ok  = 1'b0;
    store_ok = 1'b0;
    case (Funct3_i)
      F3_B, F3_H, F3_W: begin
        load_ok  = 1'b1;
        store_ok = 1'b1;
      end
      F3_BU, F3_HU: load_ok = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bad_funct3   = (Mem_Read_i & ~load_ok) | (Mem_Write_i & ~store_ok);
    misaligned   = 1'b0;
    if ((Funct3_i == F3_H) || (Funct3_i == F3_HU))
      misaligned = lane[0];
    else if (Funct3_i == F3_W)
      misaligned = (lane != 2'b00);
    out_of_range = (Address_i < BASE_ADDR) || (word_idx >= DEPTH_LIM);
  end

  // Priority: funct3 first, then alignment, then range.
  always_comb begin
    cause = 2'b00;
    if (access) begin
      if (bad_funct3)
        cause = CAUSE_FUNCT3;
      else if (misaligned)
        cause = CAUSE_MISALIGN;
      else if (out_of_range)
        cause = CAUSE_RANGE;
    end
  end

  assign Access_Error_o = (cause != 2'b00);

  // Load path: the range check gates the RAM index so out-of-range addresses never alias.
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  always_comb begin
    rd_word = '0;
    if (!out_of_range)
      rd_word = ram[ram_idx];
  end

  assign rd_shift = rd_word >> {lane, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = rd_shift[15:0];

  always_comb begin
    Read_Data_o = '0;
    if (Mem_Read_i && !Access_Error_o) begin
      case (Funct3_i)
        F3_B:    Read_Data_o = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
        F3_H:    Read_Data_o = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
        F3_W:    Read_Data_o = rd_word;
        F3_BU:   Read_Data_o = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
        F3_HU:   Read_Data_o = {{(DATA_WIDTH-16){1'b0}}, rd_half};
        default: Read_Data_o = '0;
      endcase
    end
  end

  // Store path: replicate the narrow data across lanes and let byte enables pick.
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_be;
  logic                  wr_en;

  always_comb begin
    wr_data = Write_Data_i;
    wr_be   = 4'b0000;
    case (Funct3_i)
      F3_B: begin
        wr_data = {4{Write_Data_i[7:0]}};
        wr_be   = 4'b0001 << lane;
      end
      F3_H: begin
        wr_data = {2{Write_Data_i[15:0]}};
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: wr_be = 4'b1111;
      default: ;
    endcase
  end

  assign wr_en = reset & Mem_Write_i & ~Access_Error_o;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l])
          ram[ram_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  // Clear and a new fault on the same edge: the new fault replaces the old one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Fault_Valid_o <= 1'b0;
      Fault_Cause_o <= 2'b00;
      Fault_Addr_o  <= '0;
    end else if (Access_Error_o && (!Fault_Valid_o || Fault_Clear_i)) begin
      Fault_Valid_o <= 1'b1;
      Fault_Cause_o <= cause;
      Fault_Addr_o  <= Address_i;
    end else if (Fault_Clear_i) begin
      Fault_Valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - scoreboard bench for data_memory_lsu
// Stimulus pushes expectations; a monitor drains them at each falling edge.
module tb_data_memory_lsu;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
  localparam int K_RD = 0, K_ERR = 1, K_FV = 2, K_FC = 3, K_FA = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        access_error;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic        fault_clear = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  data_memory_lsu dut (
    .clk            (clk),
    .reset          (reset),
    .Mem_Read_i     (mem_read),
    .Mem_Write_i    (mem_write),
    .Funct3_i       (funct3),
    .Address_i      (address),
    .Write_Data_i   (write_data),
    .Read_Data_o    (read_data),
    .Access_Error_o (access_error),
    .Fault_Valid_o  (fault_valid),
    .Fault_Cause_o  (fault_cause),
    .Fault_Addr_o   (fault_addr),
    .Fault_Clear_i  (fault_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_RD:    return read_data;
      K_ERR:   return {31'b0, access_error};
      K_FV:    return {31'b0, fault_valid};
      K_FC:    return {30'b0, fault_cause};
      default: return fault_addr;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e   = sb.pop_front();
        act = observe(e.kind);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    address    = addr;
    write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, W, BASE, 32'h0);
    fault_clear = 1'b0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    drive(1'b0, 1'b1, f3, addr, wd);
    step();
    idle();
  endtask

  task automatic load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp_data);
    drive(1'b1, 1'b0, f3, addr, 32'h0);
    expect_val(name, K_RD, exp_data);
    expect_val({name, "_err"}, K_ERR, 32'd0);
    step();
    idle();
  endtask

  task automatic expect_fault(input string name, input logic v, input logic [1:0] c,
                              input logic [31:0] a);
    expect_val({name, "_valid"}, K_FV, {31'b0, v});
    expect_val({name, "_cause"}, K_FC, {30'b0, c});
    expect_val({name, "_addr"}, K_FA, a);
  endtask

  initial begin
    idle();
    step();
    expect_fault("reset", 1'b0, 2'b00, 32'h0);
    step();
    reset = 1'b1;

    store(W, BASE, 32'h1111_1111);

    // Word write / readback
    store(W, BASE + 32'h4, 32'hDEAD_BEEF);
    load("lw_04", W, BASE + 32'h4, 32'hDEAD_BEEF);
    load("lw_00", W, BASE, 32'h1111_1111);

    // Byte and halfword lanes
    store(W, BASE + 32'h8, 32'h0);
    store(B, BASE + 32'hB, 32'h1234_5680);
    load("lw_08", W, BASE + 32'h8, 32'h8000_0000);
    load("lb_0b", B, BASE + 32'hB, 32'hFFFF_FF80);
    load("lbu_0b", BU, BASE + 32'hB, 32'h0000_0080);
    store(H, BASE + 32'hA, 32'hABCD_8001);
    load("lh_0a", H, BASE + 32'hA, 32'hFFFF_8001);
    load("lhu_0a", HU, BASE + 32'hA, 32'h0000_8001);
    load("lw_08b", W, BASE + 32'h8, 32'h8001_0000);
    load("lb_08", B, BASE + 32'h8, 32'h0);

    // Misaligned load, then a misaligned store that must be ignored
    drive(1'b1, 1'b0, W, BASE + 32'h2, 32'h0);
    expect_val("mis_lw_err", K_ERR, 32'd1);
    expect_val("mis_lw_rd", K_RD, 32'd0);
    step();
    idle();
    expect_fault("mis_lw", 1'b1, 2'b01, BASE + 32'h2);
    drive(1'b0, 1'b1, H, BASE + 32'h1, 32'hFFFF_FFFF);
    expect_val("mis_sh_err", K_ERR, 32'd1);
    step();
    idle();
    expect_fault("mis_sh", 1'b1, 2'b01, BASE + 32'h2);
    load("lw_00_after_sh", W, BASE, 32'h1111_1111);

    // Out of range store
    fault_clear = 1'b1;
    step();
    idle();
    expect_val("clear_valid", K_FV, 32'd0);
    drive(1'b0, 1'b1, W, BASE + 32'h100, 32'h5555_5555);
    expect_val("oor_sw_err", K_ERR, 32'd1);
    step();
    idle();
    expect_fault("oor_sw", 1'b1, 2'b10, BASE + 32'h100);
    load("lw_00_after_oor", W, BASE, 32'h1111_1111);

    // Clear coinciding with an illegal-funct3 store
    drive(1'b0, 1'b1, 3'b011, BASE + 32'h4, 32'h0);
    fault_clear = 1'b1;
    expect_val("f3_sw_err", K_ERR, 32'd1);
    step();
    idle();
    expect_fault("f3_sw", 1'b1, 2'b11, BASE + 32'h4);
    load("lw_04_after_f3", W, BASE + 32'h4, 32'hDEAD_BEEF);

    // Range and funct3 boundaries
    drive(1'b1, 1'b0, W, BASE - 32'h4, 32'h0);
    expect_val("below_base_err", K_ERR, 32'd1);
    step();
    drive(1'b1, 1'b0, BU, BASE + 32'hFF, 32'h0);
    expect_val("last_byte_err", K_ERR, 32'd0);
    step();
    drive(1'b1, 1'b0, 3'b011, BASE, 32'h0);
    expect_val("ld_f3_err", K_ERR, 32'd1);
    step();
    drive(1'b1, 1'b0, HU, BASE + 32'h3, 32'h0);
    expect_val("lhu_mis_err", K_ERR, 32'd1);
    step();
    idle();
    expect_fault("sticky", 1'b1, 2'b11, BASE + 32'h4);

    // Read during write
    store(W, BASE + 32'h10, 32'hAAAA_AAAA);
    drive(1'b1, 1'b1, W, BASE + 32'h10, 32'h1234_5678);
    expect_val("rdw_before", K_RD, 32'hAAAA_AAAA);
    step();
    drive(1'b1, 1'b0, W, BASE + 32'h10, 32'h0);
    expect_val("rdw_after", K_RD, 32'h1234_5678);
    step();
    idle();

    // Asynchronous reset with a store pending
    drive(1'b0, 1'b1, W, BASE + 32'h10, 32'h0BAD_F00D);
    #2;
    reset = 1'b0;
    expect_fault("async_rst", 1'b0, 2'b00, 32'h0);
    step();
    idle();
    reset = 1'b1;
    load("lw_10_after_rst", W, BASE + 32'h10, 32'h1234_5678);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
